// File: rtl/sc_io_mailbox.sv
// SCOMP IO-bus responder: a 4-register window that bridges SCOMP IO cycles to
// an RX FIFO (SCOMP -> host) and a TX FIFO (host -> SCOMP).
module sc_io_mailbox #(
  parameter logic [7:0]  BASE_ADDR  = 8'h10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_sc_iocyc,
  input  logic        i_sc_iowr,
  input  logic [7:0]  i_sc_ioaddr,
  inout  wire  [15:0] io_sc_iodata,
  output logic        o_rx_valid,
  output logic [15:0] o_rx_data,
  input  logic        i_rx_ready,
  input  logic        i_tx_valid,
  input  logic [15:0] i_tx_data,
  output logic        o_tx_ready
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_SCRATCH = 2'd2,
    REG_LEVELS  = 2'd3
  } reg_e;

  logic          cyc_q;
  logic          rd_act_q;
  reg_e          off_q;
  logic [15:0]   rd_q;
  logic          ovf;
  logic [15:0]   scratch;

  logic [15:0]   rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr, rx_rd;
  logic [CW-1:0] rx_count;
  logic [15:0]   tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr, tx_rd;
  logic [CW-1:0] tx_count;

  logic          start, fin, hit, wr_hit;
  reg_e          sel;
  logic          rx_push_req, rx_push, rx_pop, ovf_set, ovf_clr;
  logic          tx_push, tx_pop, tx_nonempty, rx_full;
  logic [15:0]   tx_head, rd_val;

  assign start  = i_sc_iocyc && !cyc_q;
  assign fin    = !i_sc_iocyc && cyc_q;
  assign hit    = i_sc_ioaddr[7:2] == BASE_ADDR[7:2];
  assign sel    = reg_e'(i_sc_ioaddr[1:0]);
  assign wr_hit = start && hit && i_sc_iowr;

  assign tx_nonempty = tx_count != '0;
  assign rx_full     = rx_count == DEPTH_C;
  assign o_rx_valid  = rx_count != '0;
  assign o_tx_ready  = tx_count != DEPTH_C;
  assign o_rx_data   = o_rx_valid ? rx_mem[rx_rd] : '0;
  assign tx_head     = tx_nonempty ? tx_mem[tx_rd] : '0;

  // A full RX still accepts a write when the host frees a slot on the same clock.
  assign rx_pop      = o_rx_valid && i_rx_ready;
  assign rx_push_req = wr_hit && (sel == REG_DATA);
  assign rx_push     = rx_push_req && (!rx_full || rx_pop);
  assign ovf_set     = rx_push_req && !rx_push;
  assign ovf_clr     = wr_hit && (sel == REG_STATUS) && io_sc_iodata[2];

  assign tx_push = i_tx_valid && o_tx_ready;
  assign tx_pop  = fin && rd_act_q && (off_q == REG_DATA) && tx_nonempty;

  always_comb begin
    rd_val = '0;
    unique case (sel)
      REG_DATA:    rd_val = tx_head;
      REG_STATUS:  rd_val = {13'b0, ovf, tx_nonempty, rx_full};
      REG_SCRATCH: rd_val = scratch;
      REG_LEVELS:  rd_val = {8'(rx_count), 8'(tx_count)};
      default:     rd_val = '0;
    endcase
  end

  // Start clock is never driven: rd_act_q only rises on the start edge and drops at cycle end.
  assign io_sc_iodata = (i_sc_iocyc && rd_act_q) ? rd_q : 'z;

  always_ff @(posedge i_clk) begin
    cyc_q <= i_sc_iocyc;
    if (i_reset) begin
      rd_act_q <= 1'b0;
      off_q    <= REG_DATA;
      rd_q     <= '0;
      ovf      <= 1'b0;
      scratch  <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (!cyc_q) rd_q <= rd_val;

      if (start) begin
        off_q    <= sel;
        rd_act_q <= hit && !i_sc_iowr;
      end else if (fin) begin
        rd_act_q <= 1'b0;
      end

      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      if (wr_hit && (sel == REG_SCRATCH)) scratch <= io_sc_iodata;

      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);

      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[rx_wr] <= io_sc_iodata;
    if (tx_push) tx_mem[tx_wr] <= i_tx_data;
  end

endmodule

// File: tb/tb_sc_io_mailbox.sv
// Directed bench for sc_io_mailbox; the IO data net is pulled up, so an
// undriven bus reads back as 16'hFFFF.
module tb_sc_io_mailbox;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iocyc = 1'b0;
  logic        iowr = 1'b0;
  logic [7:0]  ioaddr = '0;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready = 1'b0;
  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = '0;
  logic        tx_ready;
  logic [15:0] bus_drv = '0;
  logic        bus_en = 1'b0;
  tri1  [15:0] sc_bus;

  int total = 0;
  int bad = 0;
  logic [15:0] rd;

  assign sc_bus = bus_en ? bus_drv : 'z;

  always #5 clk = ~clk;

  sc_io_mailbox #(.BASE_ADDR(8'h10), .FIFO_DEPTH(8)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_sc_iocyc(iocyc), .i_sc_iowr(iowr), .i_sc_ioaddr(ioaddr),
    .io_sc_iodata(sc_bus),
    .o_rx_valid(rx_valid), .o_rx_data(rx_data), .i_rx_ready(rx_ready),
    .i_tx_valid(tx_valid), .i_tx_data(tx_data), .o_tx_ready(tx_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sc_write(input logic [7:0] a, input logic [15:0] d);
    iowr = 1'b1; ioaddr = a; bus_drv = d; bus_en = 1'b1;
    tick;
    iocyc = 1'b1;
    tick;
    tick;
    iocyc = 1'b0;
    tick;
    bus_en = 1'b0;
    tick;
  endtask

  task automatic sc_read(input logic [7:0] a, output logic [15:0] d);
    iowr = 1'b0; ioaddr = a;
    tick;
    iocyc = 1'b1;
    tick;
    tick;
    d = sc_bus;
    iocyc = 1'b0;
    tick;
    tick;
  endtask

  initial begin
    // reset state
    tick; tick; tick;
    reset = 1'b0;
    tick;
    check("rst_rx_valid", {15'b0, rx_valid}, 16'h0000);
    check("rst_rx_data", rx_data, 16'h0000);
    check("rst_tx_ready", {15'b0, tx_ready}, 16'h0001);
    check("rst_bus_idle", sc_bus, 16'hFFFF);
    sc_read(8'h11, rd); check("rst_status", rd, 16'h0000);
    sc_read(8'h12, rd); check("rst_scratch", rd, 16'h0000);

    // 1: SCOMP write into RX, host drains
    sc_write(8'h10, 16'hBEEF);
    check("rx_valid_after_wr", {15'b0, rx_valid}, 16'h0001);
    check("rx_data_after_wr", rx_data, 16'hBEEF);
    rx_ready = 1'b1; tick; rx_ready = 1'b0;
    check("rx_valid_after_pop", {15'b0, rx_valid}, 16'h0000);

    // 2: host fills TX, SCOMP reads it out
    tx_valid = 1'b1; tx_data = 16'h1234; tick;
    tx_data = 16'h5678; tick;
    tx_valid = 1'b0;
    sc_read(8'h10, rd); check("tx_read0", rd, 16'h1234);
    sc_read(8'h10, rd); check("tx_read1", rd, 16'h5678);
    sc_read(8'h10, rd); check("tx_read_empty", rd, 16'h0000);
    sc_read(8'h13, rd); check("levels_tx_empty", rd, 16'h0000);

    // TX full boundary: ninth push is refused
    tx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tx_data = 16'h7000 + 16'(i);
      tick;
    end
    tx_valid = 1'b0;
    check("tx_ready_full", {15'b0, tx_ready}, 16'h0000);
    sc_read(8'h13, rd); check("levels_tx_full", rd, 16'h0008);
    sc_read(8'h11, rd); check("status_tx_nonempty", rd, 16'h0002);
    for (int i = 0; i < 8; i++) begin
      sc_read(8'h10, rd); check("tx_drain", rd, 16'h7000 + 16'(i));
    end
    sc_read(8'h10, rd); check("tx_drain_empty", rd, 16'h0000);

    // 3: RX overflow and ovf clear
    for (int i = 0; i < 9; i++) sc_write(8'h10, 16'h3000 + 16'(i));
    sc_read(8'h11, rd); check("status_ovf", rd, 16'h0005);
    sc_read(8'h13, rd); check("levels_rx_full", rd, 16'h0800);
    check("rx_head_full", rx_data, 16'h3000);
    sc_write(8'h11, 16'h0004);
    sc_read(8'h11, rd); check("status_ovf_clr", rd, 16'h0001);

    // 5: full RX, SCOMP write and host pop on the same clock
    iowr = 1'b1; ioaddr = 8'h10; bus_drv = 16'h5555; bus_en = 1'b1;
    tick;
    iocyc = 1'b1; rx_ready = 1'b1;
    tick;
    rx_ready = 1'b0;
    tick;
    iocyc = 1'b0;
    tick;
    bus_en = 1'b0;
    tick;
    sc_read(8'h11, rd); check("status_push_pop", rd, 16'h0001);
    sc_read(8'h13, rd); check("levels_push_pop", rd, 16'h0800);
    for (int i = 0; i < 8; i++) begin
      check("rx_drain", rx_data, (i < 7) ? 16'h3001 + 16'(i) : 16'h5555);
      rx_ready = 1'b1; tick; rx_ready = 1'b0;
    end
    check("rx_empty_after_drain", {15'b0, rx_valid}, 16'h0000);

    // 4: scratch, bus timing, out-of-window read
    sc_write(8'h12, 16'hA5A5);
    sc_read(8'h12, rd); check("scratch_rb", rd, 16'hA5A5);
    iowr = 1'b0; ioaddr = 8'h12;
    tick;
    iocyc = 1'b1;
    #1 check("start_not_driven", sc_bus, 16'hFFFF);
    tick;
    check("scratch_driven", sc_bus, 16'hA5A5);
    iocyc = 1'b0;
    #1 check("bus_released", sc_bus, 16'hFFFF);
    tick; tick;
    sc_read(8'h14, rd); check("miss_not_driven", rd, 16'hFFFF);

    // 6: reset in the middle of a DATA read with TX non-empty
    tx_valid = 1'b1; tx_data = 16'hC0DE; tick; tx_valid = 1'b0;
    iowr = 1'b0; ioaddr = 8'h10;
    tick;
    iocyc = 1'b1;
    tick; tick;
    check("pre_reset_drive", sc_bus, 16'hC0DE);
    reset = 1'b1;
    tick;
    check("in_reset_bus", sc_bus, 16'hFFFF);
    reset = 1'b0;
    tick;
    check("post_reset_no_start", sc_bus, 16'hFFFF);
    iocyc = 1'b0;
    tick; tick;
    check("post_reset_tx_ready", {15'b0, tx_ready}, 16'h0001);
    sc_read(8'h13, rd); check("post_reset_levels", rd, 16'h0000);
    sc_read(8'h10, rd); check("post_reset_read", rd, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
